// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : intr_ctrl_if
// Brief  : Source, mask and CPU handshake bundle for the interrupt controller.
// Rev    : 1.0  initial release
// ============================================================================
interface intr_ctrl_if #(
    parameter int N_CH = 4,
    parameter int PC_W = 32
);
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] irq_src;
    logic            intr_en;
    logic            mask_we;
    logic [N_CH-1:0] mask_wdata;
    logic            ack;
    logic            eoi;
    logic            irr;
    logic [ID_W-1:0] irq_id;
    logic [PC_W-1:0] vector;
    logic            in_service;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] mask;

    modport master (
        output irq_src, intr_en, mask_we, mask_wdata, ack, eoi,
        input  irr, irq_id, vector, in_service, pending, mask
    );

    modport slave (
        input  irq_src, intr_en, mask_we, mask_wdata, ack, eoi,
        output irr, irq_id, vector, in_service, pending, mask
    );
endinterface
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : intr_ctrl
// Brief  : N-channel interrupt controller with edge/level inputs, masking,
//          fixed or round-robin arbitration and a REQ/ack/EOI handshake.
// Rev    : 1.0  initial release
// ============================================================================
module intr_ctrl #(
    parameter int              N_CH       = 4,
    parameter int              PC_W       = 32,
    parameter logic [31:0]     VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0]     VEC_STRIDE = 32'h10,
    parameter logic [N_CH-1:0] EDGE_MASK  = '1,
    parameter int              PRIO_MODE  = 0,
    parameter logic [N_CH-1:0] MASK_RST   = '0
) (
    input  logic      clk,
    input  logic      reset,
    intr_ctrl_if.slave bus
);
    localparam int              ID_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [ID_W:0]   c_nch    = (ID_W+1)'(N_CH);
    localparam logic [ID_W-1:0] c_last   = ID_W'(N_CH - 1);
    localparam logic [PC_W-1:0] c_base   = PC_W'(VEC_BASE);
    localparam logic [PC_W-1:0] c_stride = PC_W'(VEC_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N_CH-1:0] r_src_q;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_mask;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_irq_id;
    logic            r_irr;
    logic            r_in_service;

    logic [N_CH-1:0] w_elig;
    logic [N_CH-1:0] w_rot;
    logic [N_CH-1:0] w_pending_nxt;
    logic [ID_W-1:0] w_base;
    logic [ID_W:0]   w_off;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_win;
    logic            w_any;
    logic            w_ack_acc;

    assign w_elig    = r_pending & r_mask;
    assign w_any     = |w_elig;
    assign w_ack_acc = (r_state == S_REQ) && bus.ack;
    assign w_base    = (PRIO_MODE != 0) ? r_rr_ptr : '0;

    // Rotate so the search starts at the priority base, then map the offset back.
    always_comb begin
        w_rot = N_CH'({w_elig, w_elig} >> w_base);
        w_off = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (ID_W+1)'(k);
            end
        end
        w_sum = {1'b0, w_base} + w_off;
        w_win = (w_sum >= c_nch) ? ID_W'(w_sum - c_nch) : w_sum[ID_W-1:0];
    end

    // Edge channels: a new edge wins over the ack clear in the same cycle.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < N_CH; i++) begin
            if (EDGE_MASK[i]) begin
                if (bus.irq_src[i] && !r_src_q[i]) begin
                    w_pending_nxt[i] = 1'b1;
                end else if (w_ack_acc && (r_irq_id == ID_W'(i))) begin
                    w_pending_nxt[i] = 1'b0;
                end
            end else begin
                w_pending_nxt[i] = bus.irq_src[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_src_q      <= '0;
            r_pending    <= '0;
            r_mask       <= MASK_RST;
            r_rr_ptr     <= '0;
            r_irq_id     <= '0;
            r_irr        <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_src_q   <= bus.irq_src;
            r_pending <= w_pending_nxt;
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.intr_en && w_any) begin
                        r_irq_id <= w_win;
                        r_irr    <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.ack) begin
                        r_irr        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_rr_ptr     <= (r_irq_id == c_last) ? '0 : r_irq_id + 1'b1;
                        r_state      <= S_SERVICE;
                    end else if (!bus.intr_en || !w_elig[r_irq_id]) begin
                        r_irr   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (bus.eoi) begin
                        r_in_service <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.irr        = r_irr;
    assign bus.irq_id     = r_irq_id;
    assign bus.in_service = r_in_service;
    assign bus.pending    = r_pending;
    assign bus.mask       = r_mask;
    assign bus.vector     = c_base + PC_W'(r_irq_id) * c_stride;
endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_intr_ctrl
// Brief  : Vector-table and directed-sequence bench for intr_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_intr_ctrl;
    logic clk = 1'b0;
    logic rst_fix = 1'b1;
    logic rst_rr  = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    intr_ctrl_if #(.N_CH(4), .PC_W(32)) fx ();
    intr_ctrl_if #(.N_CH(4), .PC_W(32)) rr ();

    intr_ctrl #(
        .N_CH(4), .PC_W(32), .VEC_BASE(32'h100), .VEC_STRIDE(32'h10),
        .EDGE_MASK(4'hF), .PRIO_MODE(0), .MASK_RST(4'h0)
    ) u_fix (
        .clk(clk), .reset(rst_fix), .bus(fx.slave)
    );

    intr_ctrl #(
        .N_CH(4), .PC_W(32), .VEC_BASE(32'h100), .VEC_STRIDE(32'h10),
        .EDGE_MASK(4'h0), .PRIO_MODE(1), .MASK_RST(4'hF)
    ) u_rr (
        .clk(clk), .reset(rst_rr), .bus(rr.slave)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] src;
        logic       en;
        logic       mwe;
        logic [3:0] mwd;
        logic       ack;
        logic       eoi;
        logic       irr;
        logic [1:0] id;
        logic       svc;
        logic [3:0] pend;
        logic [3:0] mask;
    } vec_t;

    localparam int NV = 39;
    vec_t tbl [NV];

    function automatic vec_t v(input logic rst, input logic [3:0] src, input logic en,
                               input logic mwe, input logic [3:0] mwd, input logic ack,
                               input logic eoi, input logic irr, input logic [1:0] id,
                               input logic svc, input logic [3:0] pend, input logic [3:0] mask);
        return '{rst, src, en, mwe, mwd, ack, eoi, irr, id, svc, pend, mask};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fx_step(input logic [3:0] src, input logic en, input logic ack, input logic eoi);
        fx.irq_src = src; fx.intr_en = en; fx.ack = ack; fx.eoi = eoi;
        fx.mask_we = 1'b0; fx.mask_wdata = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic rr_step(input logic [3:0] src, input logic ack, input logic eoi);
        rr.irq_src = src; rr.ack = ack; rr.eoi = eoi;
        @(posedge clk); #1;
    endtask

    initial begin
        fx.irq_src = '0; fx.intr_en = 1'b0; fx.mask_we = 1'b0; fx.mask_wdata = '0;
        fx.ack = 1'b0; fx.eoi = 1'b0;
        rr.irq_src = '0; rr.intr_en = 1'b0; rr.mask_we = 1'b0; rr.mask_wdata = '0;
        rr.ack = 1'b0; rr.eoi = 1'b0;

        //            rst src  en mwe mwd  ack eoi | irr id svc pend mask
        tbl[0]  = v(1, 4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 0, 4'h0, 4'h0);
        tbl[1]  = v(1, 4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 0, 4'h0, 4'h0);
        tbl[2]  = v(0, 4'h0, 1, 1, 4'hF, 0, 0,  0, 0, 0, 4'h0, 4'hF);
        tbl[3]  = v(0, 4'h4, 1, 0, 4'h0, 0, 0,  0, 0, 0, 4'h4, 4'hF);
        tbl[4]  = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  1, 2, 0, 4'h4, 4'hF);
        tbl[5]  = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  1, 2, 0, 4'h4, 4'hF);
        tbl[6]  = v(0, 4'h0, 1, 0, 4'h0, 1, 0,  0, 2, 1, 4'h0, 4'hF);
        tbl[7]  = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  0, 2, 1, 4'h0, 4'hF);
        tbl[8]  = v(0, 4'h0, 1, 0, 4'h0, 0, 1,  0, 2, 0, 4'h0, 4'hF);
        tbl[9]  = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  0, 2, 0, 4'h0, 4'hF);
        tbl[10] = v(0, 4'hA, 1, 0, 4'h0, 0, 0,  0, 2, 0, 4'hA, 4'hF);
        tbl[11] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  1, 1, 0, 4'hA, 4'hF);
        tbl[12] = v(0, 4'h0, 1, 0, 4'h0, 1, 0,  0, 1, 1, 4'h8, 4'hF);
        tbl[13] = v(0, 4'h0, 1, 0, 4'h0, 0, 1,  0, 1, 0, 4'h8, 4'hF);
        tbl[14] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  1, 3, 0, 4'h8, 4'hF);
        tbl[15] = v(0, 4'h0, 1, 0, 4'h0, 1, 0,  0, 3, 1, 4'h0, 4'hF);
        tbl[16] = v(0, 4'h0, 1, 0, 4'h0, 0, 1,  0, 3, 0, 4'h0, 4'hF);
        tbl[17] = v(0, 4'h4, 1, 0, 4'h0, 0, 0,  0, 3, 0, 4'h4, 4'hF);
        tbl[18] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  1, 2, 0, 4'h4, 4'hF);
        tbl[19] = v(0, 4'h0, 0, 0, 4'h0, 0, 0,  0, 2, 0, 4'h4, 4'hF);
        tbl[20] = v(0, 4'h0, 0, 0, 4'h0, 0, 0,  0, 2, 0, 4'h4, 4'hF);
        tbl[21] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  1, 2, 0, 4'h4, 4'hF);
        tbl[22] = v(0, 4'h0, 0, 0, 4'h0, 1, 0,  0, 2, 1, 4'h0, 4'hF);
        tbl[23] = v(0, 4'h0, 1, 0, 4'h0, 0, 1,  0, 2, 0, 4'h0, 4'hF);
        tbl[24] = v(0, 4'h0, 1, 1, 4'h0, 0, 0,  0, 2, 0, 4'h0, 4'h0);
        tbl[25] = v(0, 4'h1, 1, 0, 4'h0, 0, 0,  0, 2, 0, 4'h1, 4'h0);
        tbl[26] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  0, 2, 0, 4'h1, 4'h0);
        tbl[27] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  0, 2, 0, 4'h1, 4'h0);
        tbl[28] = v(0, 4'h0, 1, 1, 4'h1, 0, 0,  0, 2, 0, 4'h1, 4'h1);
        tbl[29] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  1, 0, 0, 4'h1, 4'h1);
        tbl[30] = v(0, 4'h0, 1, 0, 4'h0, 1, 0,  0, 0, 1, 4'h0, 4'h1);
        tbl[31] = v(1, 4'h0, 1, 0, 4'h0, 0, 0,  0, 0, 0, 4'h0, 4'h0);
        tbl[32] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  0, 0, 0, 4'h0, 4'h0);
        tbl[33] = v(1, 4'h1, 1, 0, 4'h0, 0, 0,  0, 0, 0, 4'h0, 4'h0);
        tbl[34] = v(0, 4'h1, 1, 1, 4'hF, 0, 0,  0, 0, 0, 4'h1, 4'hF);
        tbl[35] = v(0, 4'h1, 1, 0, 4'h0, 0, 0,  1, 0, 0, 4'h1, 4'hF);
        tbl[36] = v(0, 4'h1, 1, 0, 4'h0, 1, 0,  0, 0, 1, 4'h0, 4'hF);
        tbl[37] = v(0, 4'h0, 1, 0, 4'h0, 0, 1,  0, 0, 0, 4'h0, 4'hF);
        tbl[38] = v(0, 4'h0, 1, 0, 4'h0, 0, 0,  0, 0, 0, 4'h0, 4'hF);

        for (int i = 0; i < NV; i++) begin
            rst_fix       = tbl[i].rst;
            fx.irq_src    = tbl[i].src;
            fx.intr_en    = tbl[i].en;
            fx.mask_we    = tbl[i].mwe;
            fx.mask_wdata = tbl[i].mwd;
            fx.ack        = tbl[i].ack;
            fx.eoi        = tbl[i].eoi;
            @(posedge clk); #1;
            chk($sformatf("v%0d irr", i),  32'(fx.irr),        32'(tbl[i].irr));
            chk($sformatf("v%0d id", i),   32'(fx.irq_id),     32'(tbl[i].id));
            chk($sformatf("v%0d svc", i),  32'(fx.in_service), 32'(tbl[i].svc));
            chk($sformatf("v%0d pend", i), 32'(fx.pending),    32'(tbl[i].pend));
            chk($sformatf("v%0d mask", i), 32'(fx.mask),       32'(tbl[i].mask));
            chk($sformatf("v%0d vec", i),  fx.vector, 32'h100 + 32'(tbl[i].id) * 32'h10);
        end

        // New edge on channel 0 in the same cycle as its ack keeps it pending.
        fx_step(4'h1, 1'b1, 1'b0, 1'b0);
        chk("edge_ack pend_set", 32'(fx.pending), 32'h1);
        fx_step(4'h0, 1'b1, 1'b0, 1'b0);
        chk("edge_ack irr", 32'(fx.irr), 32'h1);
        chk("edge_ack id", 32'(fx.irq_id), 32'h0);
        fx_step(4'h1, 1'b1, 1'b1, 1'b0);
        chk("edge_ack svc", 32'(fx.in_service), 32'h1);
        chk("edge_ack pend_kept", 32'(fx.pending), 32'h1);
        fx_step(4'h0, 1'b1, 1'b0, 1'b1);
        chk("edge_ack eoi_irr", 32'(fx.irr), 32'h0);
        fx_step(4'h0, 1'b1, 1'b0, 1'b0);
        chk("edge_ack represent", 32'(fx.irr), 32'h1);
        chk("edge_ack re_id", 32'(fx.irq_id), 32'h0);
        chk("edge_ack re_vec", fx.vector, 32'h100);

        // Round-robin: level channels 0 and 1 held high alternate grants.
        rst_rr = 1'b1;
        rr_step(4'h0, 1'b0, 1'b0);
        chk("rr reset_mask", 32'(rr.mask), 32'hF);
        chk("rr reset_vec", rr.vector, 32'h100);
        rst_rr = 1'b0;
        rr.intr_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int cyc;
            cyc = 0;
            rr.irq_src = 4'h3; rr.ack = 1'b0; rr.eoi = 1'b0;
            while (!rr.irr && cyc < 10) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("rr%0d irr_seen", r), 32'(rr.irr), 32'h1);
            chk($sformatf("rr%0d id", r), 32'(rr.irq_id), 32'(r % 2));
            chk($sformatf("rr%0d vec", r), rr.vector, 32'h100 + 32'(r % 2) * 32'h10);
            rr_step(4'h3, 1'b1, 1'b0);
            chk($sformatf("rr%0d svc", r), 32'(rr.in_service), 32'h1);
            chk($sformatf("rr%0d level_pend", r), 32'(rr.pending), 32'h3);
            rr_step(4'h3, 1'b0, 1'b1);
            chk($sformatf("rr%0d eoi", r), 32'(rr.in_service), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised interrupt controller between peripheral interrupt sources and the CPU's `irr` / `intr_en` / `ack` special-register path. It generalises the single interrupt-request bit to `N_CH` channels. Each channel has edge or level sensitivity, a mask bit and a pending latch. Arbitration is fixed-priority or round-robin. A request/acknowledge/end-of-interrupt FSM presents one winner at a time to the CPU, together with the channel id and handler vector address.

## Interface
Parameters:
- `N_CH`, 4: number of interrupt channels (1..16).
- `PC_W`, 32: width of the vector output; matches pc width.
- `VEC_BASE`, 32'h0000_0100: vector address of channel 0.
- `VEC_STRIDE`, 32'h10: address spacing between channel vectors.
- `EDGE_MASK`, all ones: bit i = 1 makes channel i rising-edge sensitive; 0 makes it level sensitive.
- `PRIO_MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `MASK_RST`, 0: mask register value at reset.

Ports (`ID_W` = max(1, clog2(`N_CH`))):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_src`  in  `N_CH`  interrupt source lines, synchronous to `clk`.
- `intr_en`  in  1  global interrupt enable from the CPU.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  `N_CH`  new mask value; 1 = channel enabled.
- `ack`  in  1  CPU accepts the presented interrupt.
- `eoi`  in  1  CPU signals end of interrupt handler.
- `irr`  out  1  interrupt request to the CPU.
- `irq_id`  out  `ID_W`  channel currently presented or in service.
- `vector`  out  `PC_W`  equals `VEC_BASE + irq_id*VEC_STRIDE`, truncated to `PC_W`.
- `in_service`  out  1  a handler is active.
- `pending`  out  `N_CH`  pending latch contents.
- `mask`  out  `N_CH`  mask register contents.

## Operation
Channel inputs:
- `src_q` is a 1-cycle registered copy of `irq_src`.
- Edge channel: `pending[i]` sets when `irq_src[i] & ~src_q[i]`. It clears when an ack is accepted with `irq_id == i`. If set and clear occur in the same cycle, set wins.
- Level channel: `pending[i]` <= `irq_src[i]` every cycle. Ack does not clear it.
- `mask` <= `mask_wdata` when `mask_we` is high.

Eligibility:
- `elig = pending & mask`, evaluated on registered values.
- Fixed mode: the lowest set bit wins.
- Round-robin mode: the first set bit at or above `rr_ptr` wins, wrapping modulo `N_CH`.
- On every accepted ack, `rr_ptr` <= (granted id + 1) mod `N_CH`.

FSM states: IDLE, REQ, SERVICE.
- IDLE: if `intr_en && |elig`, latch the winner into `irq_id`, set `irr` = 1, and go to REQ. Otherwise stay.
- REQ: `irr` and `irq_id` are held stable.
  - On `ack`: `irr` <= 0, `in_service` <= 1, clear pending (edge channels), update `rr_ptr`, go to SERVICE.
  - Else, if `!intr_en` or `!elig[irq_id]` (the request is withdrawn): `irr` <= 0, go to IDLE. Pending is retained.
  - If ack and withdrawal occur in the same cycle, ack wins.
- SERVICE: on `eoi`, `in_service` <= 0 and go to IDLE. There is no nesting; new sources only accumulate in `pending`.
- `ack` outside REQ and `eoi` outside SERVICE are ignored.
- `vector` is combinational from the `irq_id` register.

Reset (synchronous): state IDLE; `irr` = 0; `in_service` = 0; `irq_id` = 0; `pending` = 0; `src_q` = 0; `rr_ptr` = 0; `mask` = `MASK_RST`. Consequently `vector` = `VEC_BASE`.
- A source held high across reset release registers as a rising edge in the first cycle after reset.
- Reset asserted in REQ or SERVICE aborts immediately; no ack or eoi is required afterwards.

## Timing
- Source sampled high at edge k: `pending` is set after edge k, and `irr` rises after edge k+1. Latency is 2 cycles from source to `irr`.
- `ack` sampled at edge m: `irr` = 0 and `in_service` = 1 after edge m. In an edge channel, `pending[id]` = 0 after edge m unless a new edge is seen at m.
- `eoi` sampled at edge n: IDLE after edge n. The earliest next `irr` is after edge n+1.
- A mask write at edge k affects eligibility from cycle k+1.
- Withdrawal drops `irr` one cycle after the condition is sampled.
- Steady-state throughput: one interrupt per 3 cycles (REQ, SERVICE, IDLE).

## Test plan
Defaults: `N_CH`=4, `VEC_BASE`=0x100, `VEC_STRIDE`=0x10.
- Reset, mask=0xF, `intr_en`=1, pulse `irq_src`[2] for 1 cycle -> `irr` rises 2 cycles later, `irq_id`=2, `vector`=0x120, `pending`=4'b0100. Then ack -> `pending`=0, `in_service`=1. Then eoi -> `irr` stays 0.
- Fixed mode, pend channels 1 and 3 together -> channel 1 served first (`vector`=0x110). After eoi, channel 3 is presented (`vector`=0x130) 2 cycles after eoi.
- `PRIO_MODE`=1, hold channels 0 and 1 level-high, perform 4 ack/eoi rounds -> granted ids are 0, 1, 0, 1.
- In REQ on channel 2, drop `intr_en` -> `irr` falls next cycle and `pending`[2] stays 1. Re-enable -> `irr` returns after 1 cycle with `irq_id`=2. Repeat with ack and `intr_en` drop in the same cycle -> enters SERVICE.
- `mask`=0, pend channel 0 -> no `irr`. Write `mask`=0x1 -> `irr` appears 2 cycles after the write. Assert `reset` in SERVICE -> all outputs return to reset values the next cycle.
- Edge channel 0: a new rising edge on the same cycle as the ack of channel 0 -> `pending`[0]=1 after the ack, and the channel is re-presented after eoi.
